// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush controller: priority stall merge, multi-cycle EX
// sequencing, data-bus wait watchdog and saturating stall-cycle counter.
module pipe_stall_ctrl #(
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_cycles,
    input  logic              stallreq_mem,
    input  logic              flush_req,
    input  logic              perf_clr,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              mc_busy,
    output logic              mc_done,
    output logic              bus_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              ex_stall;

    // Multi-cycle op sequencer; the counter runs regardless of which stall wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start && !flush_req) begin
                        state <= BUSY;
                        cnt   <= (mc_cycles == '0) ? CNT_W'(1) : mc_cycles;
                    end
                end
                BUSY: begin
                    if (flush_req) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ex_stall = stallreq_ex
                    | ((state == IDLE) & mc_start & !flush_req)
                    | (state == BUSY);

    assign mc_busy = (state == BUSY);
    // A flush landing on the completion cycle cancels the result.
    assign mc_done = (state == DONE) & !flush_req;

    // Priority merge; forced quiet while reset is asserted.
    always_comb begin
        stall = 6'b000000;
        flush = 1'b0;
        if (!rst) begin
            stall = 6'b000000;
        end else if (flush_req) begin
            flush = 1'b1;
        end else if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (ex_stall) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end else if (stallreq_if) begin
            stall = 6'b000011;
        end
    end

    // Data-bus watchdog: wraps to zero on expiry and keeps counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt      <= '0;
            bus_timeout <= 1'b0;
        end else if (!stallreq_mem || flush_req) begin
            wd_cnt      <= '0;
            bus_timeout <= 1'b0;
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            wd_cnt      <= '0;
            bus_timeout <= 1'b1;
        end else begin
            wd_cnt      <= wd_cnt + WD_W'(1);
            bus_timeout <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (stall[0] && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_pipe_stall_ctrl;

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned PERF_W  = 4;

    localparam logic [6:0] R_IF  = 7'h01;
    localparam logic [6:0] R_ID  = 7'h02;
    localparam logic [6:0] R_EX  = 7'h04;
    localparam logic [6:0] R_MCS = 7'h08;
    localparam logic [6:0] R_MEM = 7'h10;
    localparam logic [6:0] R_FL  = 7'h20;
    localparam logic [6:0] R_CLR = 7'h40;

    localparam logic [3:0] O_FL   = 4'h8;
    localparam logic [3:0] O_BUSY = 4'h4;
    localparam logic [3:0] O_DONE = 4'h2;
    localparam logic [3:0] O_TMO  = 4'h1;

    logic              clk = 1'b1;
    logic              rst;
    logic              stallreq_if, stallreq_id, stallreq_ex, mc_start;
    logic [CNT_W-1:0]  mc_cycles;
    logic              stallreq_mem, flush_req, perf_clr;
    logic [5:0]        stall;
    logic              flush, mc_busy, mc_done, bus_timeout;
    logic [PERF_W-1:0] stall_cycles;

    typedef struct {
        int         id;
        logic [5:0] stall;
        logic [3:0] outs;
        int         perf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT),
        .PERF_W (PERF_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .mc_start    (mc_start),
        .mc_cycles   (mc_cycles),
        .stallreq_mem(stallreq_mem),
        .flush_req   (flush_req),
        .perf_clr    (perf_clr),
        .stall       (stall),
        .flush       (flush),
        .mc_busy     (mc_busy),
        .mc_done     (mc_done),
        .bus_timeout (bus_timeout),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d %s: got %0h expected %0h", id, nm, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",       e.id, 32'(stall),       32'(e.stall));
            chk("flush",       e.id, 32'(flush),       32'(e.outs[3]));
            chk("mc_busy",     e.id, 32'(mc_busy),     32'(e.outs[2]));
            chk("mc_done",     e.id, 32'(mc_done),     32'(e.outs[1]));
            chk("bus_timeout", e.id, 32'(bus_timeout), 32'(e.outs[0]));
            if (e.perf >= 0) begin
                chk("stall_cycles", e.id, 32'(stall_cycles), 32'(e.perf));
            end
        end
    end

    task automatic step(input logic r, input logic [6:0] req, input logic [CNT_W-1:0] mcc,
                        input logic [5:0] es, input logic [3:0] eo, input int ep);
        exp_t e;
        rst          = r;
        stallreq_if  = req[0];
        stallreq_id  = req[1];
        stallreq_ex  = req[2];
        mc_start     = req[3];
        stallreq_mem = req[4];
        flush_req    = req[5];
        perf_clr     = req[6];
        mc_cycles    = mcc;
        e.id    = step_no;
        e.stall = es;
        e.outs  = eo;
        e.perf  = ep;
        q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {stallreq_if, stallreq_id, stallreq_ex, mc_start} = 4'b0;
        {stallreq_mem, flush_req, perf_clr} = 3'b0;
        mc_cycles = '0;
        @(posedge clk);
        #1;

        // Reset held with every request high
        step(1'b0, 7'h7F, 6'd3, 6'b000000, 4'h0, 0);
        step(1'b0, 7'h7F, 6'd3, 6'b000000, 4'h0, 0);
        step(1'b1, 7'h00, 6'd0, 6'b000000, 4'h0, 0);

        // Priority ladder
        step(1'b1, R_IF | R_ID,                 6'd0, 6'b000111, 4'h0, 0);
        step(1'b1, R_IF | R_ID | R_MEM,         6'd0, 6'b011111, 4'h0, 1);
        step(1'b1, R_IF | R_ID | R_MEM | R_FL,  6'd0, 6'b000000, O_FL, 2);
        step(1'b1, R_IF,                        6'd0, 6'b000011, 4'h0, 2);
        step(1'b1, R_EX,                        6'd0, 6'b001111, 4'h0, 3);
        step(1'b1, 7'h00,                       6'd0, 6'b000000, 4'h0, 4);

        // Perf counter: clear while stalled, then saturate
        step(1'b1, R_CLR | R_IF, 6'd0, 6'b000011, 4'h0, 4);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, R_IF, 6'd0, 6'b000011, 4'h0, (k > 15) ? 15 : k);
        end
        step(1'b1, 7'h00,        6'd0, 6'b000000, 4'h0, 15);
        step(1'b1, R_CLR | R_IF, 6'd0, 6'b000011, 4'h0, 15);
        step(1'b1, 7'h00,        6'd0, 6'b000000, 4'h0, 0);

        // Multi-cycle op, N=3; mc_start during DONE is ignored
        step(1'b1, R_MCS, 6'd3, 6'b001111, 4'h0,   -1);
        step(1'b1, 7'h00, 6'd0, 6'b001111, O_BUSY, -1);
        step(1'b1, 7'h00, 6'd0, 6'b001111, O_BUSY, -1);
        step(1'b1, 7'h00, 6'd0, 6'b001111, O_BUSY, -1);
        step(1'b1, R_MCS, 6'd0, 6'b000000, O_DONE, -1);
        step(1'b1, 7'h00, 6'd0, 6'b000000, 4'h0,   -1);

        // N=0 behaves as N=1
        step(1'b1, R_MCS, 6'd0, 6'b001111, 4'h0,   -1);
        step(1'b1, 7'h00, 6'd0, 6'b001111, O_BUSY, -1);
        step(1'b1, 7'h00, 6'd0, 6'b000000, O_DONE, -1);
        step(1'b1, 7'h00, 6'd0, 6'b000000, 4'h0,   -1);

        // Abort in BUSY
        step(1'b1, R_MCS, 6'd5, 6'b001111, 4'h0,          -1);
        step(1'b1, 7'h00, 6'd0, 6'b001111, O_BUSY,        -1);
        step(1'b1, 7'h00, 6'd0, 6'b001111, O_BUSY,        -1);
        step(1'b1, R_FL,  6'd0, 6'b000000, O_FL | O_BUSY, -1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 7'h00, 6'd0, 6'b000000, 4'h0, -1);
        end

        // Flush on the DONE cycle suppresses mc_done
        step(1'b1, R_MCS, 6'd1, 6'b001111, 4'h0,   -1);
        step(1'b1, 7'h00, 6'd0, 6'b001111, O_BUSY, -1);
        step(1'b1, R_FL,  6'd0, 6'b000000, O_FL,   -1);
        step(1'b1, 7'h00, 6'd0, 6'b000000, 4'h0,   -1);

        // Mem stall masks EX while the counter keeps running
        step(1'b1, R_MCS | R_MEM, 6'd2, 6'b011111, 4'h0,   -1);
        step(1'b1, R_MEM,         6'd0, 6'b011111, O_BUSY, -1);
        step(1'b1, R_MEM,         6'd0, 6'b011111, O_BUSY, -1);
        step(1'b1, 7'h00,         6'd0, 6'b000000, O_DONE, -1);
        step(1'b1, 7'h00,         6'd0, 6'b000000, 4'h0,   -1);

        // Watchdog: 10 cycles of mem wait, pulses on cycles 4 and 8
        for (int c = 0; c < 10; c++) begin
            step(1'b1, R_MEM, 6'd0, 6'b011111, (c == 4 || c == 8) ? O_TMO : 4'h0, -1);
        end
        step(1'b1, 7'h00, 6'd0, 6'b000000, 4'h0, -1);

        // Watchdog: request dropped before expiry
        for (int c = 0; c < 3; c++) begin
            step(1'b1, R_MEM, 6'd0, 6'b011111, 4'h0, -1);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 7'h00, 6'd0, 6'b000000, 4'h0, -1);
        end

        // Reset mid-operation
        step(1'b1, R_MCS, 6'd5, 6'b001111, 4'h0,   -1);
        step(1'b1, 7'h00, 6'd0, 6'b001111, O_BUSY, -1);
        step(1'b0, R_EX,  6'd0, 6'b000000, 4'h0,   0);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 7'h00, 6'd0, 6'b000000, 4'h0, 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
